axis_frame_source: RTL

// - AXI4-Stream master that replays a locally buffered frame into the s_axis port of conv_wrap.
// - Host or testbench loads words through a simple write port, then pulses start.
// - Emits frame_len beats with last on the final beat and backpressure honoured; one clock domain.

---
 rtl/axis_frame_source_if.sv | 13 +
 rtl/axis_frame_source.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axis_frame_source_if.sv
// rtl/axis_frame_source_if.sv - stream bundle (valid/data/ready/last/keep) for axis_frame_source
interface axis_frame_source_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;
  logic                  last;
  logic [3:0]            keep;

  modport master (output valid, data, last, keep, input ready);
  modport slave  (input valid, data, last, keep, output ready);
endinterface

// File: rtl/axis_frame_source.sv
// rtl/axis_frame_source.sv - replays a locally buffered frame as a stream master; optional AXIS_SRC_REPEAT_EN adds frame repeats
module axis_frame_source #(
  parameter int AXI_BUS_WIDTH = 32,
  parameter int DEPTH         = 1024,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset,
  input  logic                     wr_en,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [AXI_BUS_WIDTH-1:0] wr_data,
  input  logic                     start,
  input  logic [ADDR_WIDTH:0]      frame_len,
`ifdef AXIS_SRC_REPEAT_EN
  input  logic [7:0]               repeat_count,
  output logic [ADDR_WIDTH+8:0]    beat_count,
`else
  output logic [ADDR_WIDTH:0]      beat_count,
`endif
  output logic                     busy,
  output logic                     done,
  axis_frame_source_if.master      m_axis
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [AXI_BUS_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH:0]      len;
  logic [ADDR_WIDTH:0]      rd_ptr;
  logic [ADDR_WIDTH:0]      start_len;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [AXI_BUS_WIDTH-1:0] rd_word;

  logic                     out_valid;
  logic                     out_last;
  logic [AXI_BUS_WIDTH-1:0] out_data;

  logic                     hs;
  logic                     load;
  logic                     wrap;
  logic                     more_repeats;

`ifdef AXIS_SRC_REPEAT_EN
  logic [7:0] rep_left;
  assign more_repeats = (rep_left != 8'd0);
`else
  assign more_repeats = 1'b0;
`endif

  // Frame buffer write port; contents deliberately survive reset
  always_ff @(posedge axi_clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_LEN)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read side: pick the next word, restart at word 0 when another repeat is pending
  always_comb begin
    start_len = (frame_len > DEPTH_LEN) ? DEPTH_LEN : frame_len;
    hs        = out_valid && m_axis.ready;
    wrap      = (rd_ptr == len) && more_repeats;
    load      = (state == STREAM) && (!out_valid || m_axis.ready) &&
                ((rd_ptr < len) || wrap);
    rd_addr   = (rd_ptr < len) ? rd_ptr[ADDR_WIDTH-1:0] : '0;
    // A write landing on the word being fetched wins over the stored copy
    rd_word   = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

  // FSM state register
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: start only honoured in IDLE, DONE lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (start_len == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (hs && out_last && !more_repeats) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output register, read pointer, beat counter and repeat bookkeeping
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      beat_count <= '0;
      rd_ptr     <= '0;
      len        <= '0;
`ifdef AXIS_SRC_REPEAT_EN
      rep_left   <= 8'd0;
`endif
    end else begin
      if ((state == IDLE) && start) begin
        len        <= start_len;
        rd_ptr     <= '0;
        beat_count <= '0;
`ifdef AXIS_SRC_REPEAT_EN
        rep_left   <= repeat_count;
`endif
      end else begin
        if (hs) begin
          beat_count <= beat_count + 1'b1;
        end
        if (load) begin
          out_valid <= 1'b1;
          out_data  <= rd_word;
          if (wrap) begin
            rd_ptr   <= (ADDR_WIDTH+1)'(1);
            out_last <= (len == (ADDR_WIDTH+1)'(1));
`ifdef AXIS_SRC_REPEAT_EN
            rep_left <= rep_left - 8'd1;
`endif
          end else begin
            rd_ptr   <= rd_ptr + 1'b1;
            out_last <= (rd_ptr == (len - 1'b1));
          end
        end else if (hs) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

  assign m_axis.valid = out_valid;
  assign m_axis.data  = out_data;
  assign m_axis.last  = out_last;
  assign m_axis.keep  = out_valid ? 4'hF : 4'h0;

  assign busy = (state == STREAM);
  assign done = (state == DONE);

endmodule
